// File: rtl/rom_cycle_ctrl_if.sv
// Zorro III ROM cycle bus bundle: bus-side strobes/address/data plus the
// SPI ROM engine handshake. The controller uses the slave view; whatever
// drives the bus and the SPI engine uses the master view.
interface rom_cycle_ctrl_if;
    logic        FCS_n;
    logic [7:0]  ADDRH;
    logic [7:0]  rom_base;
    logic        configured;
    logic        READ;
    logic        DOE;
    logic [3:0]  DS_n;
    logic [31:0] D_in;
    logic        spi_dtack;
    logic        spi_read;
    logic [7:0]  spi_dataout;
    logic        romcycle;
    logic [7:0]  spi_datain;
    logic        DTACK_n;
    logic        BERR_n;
    logic        data_oe;
    logic [31:0] data_out;

    modport master (
        output FCS_n, ADDRH, rom_base, configured, READ, DOE, DS_n, D_in,
        output spi_dtack, spi_read, spi_dataout,
        input  romcycle, spi_datain, DTACK_n, BERR_n, data_oe, data_out
    );

    modport slave (
        input  FCS_n, ADDRH, rom_base, configured, READ, DOE, DS_n, D_in,
        input  spi_dtack, spi_read, spi_dataout,
        output romcycle, spi_datain, DTACK_n, BERR_n, data_oe, data_out
    );
endinterface

// File: rtl/rom_cycle_ctrl.sv
// ROM cycle controller: decodes a Zorro III full cycle aimed at the ROM
// window, hands the cycle to the SPI ROM engine, and terminates it on the
// bus with DTACK_n (engine completed) or BERR_n (engine never answered).
module rom_cycle_ctrl #(
    parameter logic [7:0] TIMEOUT        = 8'd255,
    parameter bit         LANE_REPLICATE = 1'b1
) (
    input  logic         clk,
    input  logic         IORST_n,
    rom_cycle_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_ACK    = 2'd2,
        S_BERR   = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_romcycle;
    logic        r_dtack_n;
    logic        r_berr_n;
    logic        r_data_oe;
    logic [7:0]  r_data_rd;
    logic [7:0]  r_spi_datain;
    logic [7:0]  r_tmo;

    logic        w_match;
    logic [7:0]  w_wr_byte;
    logic [31:0] w_data_out;

    // Cycle is ours when the full cycle strobe is down, the board is
    // configured, A31:24 hits the ROM window and at least one lane strobes.
    assign w_match = !bus.FCS_n && bus.configured &&
                     (bus.ADDRH == bus.rom_base) && !(&bus.DS_n);

    // Write byte comes from the most significant strobed lane.
    always_comb begin
        w_wr_byte = 8'h00;
        if (!bus.DS_n[3])      w_wr_byte = bus.D_in[31:24];
        else if (!bus.DS_n[2]) w_wr_byte = bus.D_in[23:16];
        else if (!bus.DS_n[1]) w_wr_byte = bus.D_in[15:8];
        else if (!bus.DS_n[0]) w_wr_byte = bus.D_in[7:0];
    end

    // Cycle sequencing; all bus-visible controls are registered here.
    always_ff @(posedge clk or negedge IORST_n) begin
        if (!IORST_n) begin
            r_state      <= S_IDLE;
            r_romcycle   <= 1'b0;
            r_dtack_n    <= 1'b1;
            r_berr_n     <= 1'b1;
            r_data_oe    <= 1'b0;
            r_data_rd    <= 8'h00;
            r_spi_datain <= 8'h00;
            r_tmo        <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_match) begin
                        r_state      <= S_ACTIVE;
                        r_romcycle   <= 1'b1;
                        r_tmo        <= 8'h00;
                        r_spi_datain <= w_wr_byte;
                    end
                end
                S_ACTIVE: begin
                    if (bus.FCS_n) begin
                        // Master gave up before termination: drop quietly.
                        r_state    <= S_IDLE;
                        r_romcycle <= 1'b0;
                    end else if (bus.spi_dtack) begin
                        // Completion beats a timeout landing on the same edge.
                        r_state   <= S_ACK;
                        r_dtack_n <= 1'b0;
                        r_data_oe <= bus.READ && bus.DOE;
                        r_data_rd <= (bus.READ && bus.spi_read) ? bus.spi_dataout : 8'h00;
                    end else if (r_tmo == TIMEOUT) begin
                        r_state    <= S_BERR;
                        r_romcycle <= 1'b0;
                        r_berr_n   <= 1'b0;
                    end else if (r_tmo != 8'hFF) begin
                        r_tmo <= r_tmo + 8'd1;
                    end
                end
                S_ACK: begin
                    if (bus.FCS_n) begin
                        r_state    <= S_IDLE;
                        r_dtack_n  <= 1'b1;
                        r_data_oe  <= 1'b0;
                        r_romcycle <= 1'b0;
                    end else begin
                        r_data_oe <= bus.READ && bus.DOE;
                    end
                end
                S_BERR: begin
                    if (bus.FCS_n) begin
                        r_state  <= S_IDLE;
                        r_berr_n <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Read data lane steering: either every lane or only the strobed ones.
    for (genvar g = 0; g < 4; g++) begin : g_lane
        if (LANE_REPLICATE) begin : g_rep
            assign w_data_out[g*8 +: 8] = r_data_rd;
        end else begin : g_sel
            assign w_data_out[g*8 +: 8] = bus.DS_n[g] ? 8'h00 : r_data_rd;
        end
    end

    assign bus.romcycle   = r_romcycle;
    assign bus.spi_datain = r_spi_datain;
    assign bus.DTACK_n    = r_dtack_n;
    assign bus.BERR_n     = r_berr_n;
    assign bus.data_oe    = r_data_oe;
    assign bus.data_out   = w_data_out;

endmodule

// File: tb/tb_rom_cycle_ctrl.sv
// Bench for rom_cycle_ctrl: directed scenarios with literal expectations,
// then randomized bus/SPI activity checked every cycle against a
// transaction-level model of the ROM cycle.
module tb_rom_cycle_ctrl;
    localparam logic [7:0] TMO = 8'd12;

    logic clk = 1'b0;
    logic IORST_n;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   chk_en = 1'b0;

    rom_cycle_ctrl_if bus ();

    rom_cycle_ctrl #(.TIMEOUT(TMO), .LANE_REPLICATE(1'b0)) dut (
        .clk(clk), .IORST_n(IORST_n), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 no cycle, 1 waiting on engine, 2 acknowledged, 3 errored
    int         m_phase = 0;
    int         m_clks = 0;   // edges spent waiting on the engine
    logic       m_romcycle = 0, m_dtack_n = 1, m_berr_n = 1, m_oe = 0;
    logic [7:0] m_rd = 0, m_wr = 0;

    function automatic logic [7:0] top_lane(input logic [3:0] ds, input logic [31:0] d);
        for (int i = 3; i >= 0; i--)
            if (!ds[i]) return d[i*8 +: 8];
        return 8'h00;
    endfunction

    initial forever begin
        @(posedge clk or negedge IORST_n);
        if (!IORST_n) begin
            m_phase = 0; m_clks = 0; m_romcycle = 0; m_dtack_n = 1;
            m_berr_n = 1; m_oe = 0; m_rd = 0; m_wr = 0;
        end else begin
            case (m_phase)
                0: if (!bus.FCS_n && bus.configured && bus.ADDRH == bus.rom_base &&
                       bus.DS_n != 4'hF) begin
                       m_phase = 1; m_clks = 0; m_romcycle = 1;
                       m_wr = top_lane(bus.DS_n, bus.D_in);
                   end
                1: begin
                       m_clks++;
                       if (bus.FCS_n) begin
                           m_phase = 0; m_romcycle = 0;
                       end else if (bus.spi_dtack) begin
                           m_phase = 2; m_dtack_n = 0; m_oe = bus.READ & bus.DOE;
                           m_rd = (bus.READ & bus.spi_read) ? bus.spi_dataout : 8'h00;
                       end else if (m_clks == int'(TMO) + 1) begin
                           m_phase = 3; m_romcycle = 0; m_berr_n = 0;
                       end
                   end
                2: if (bus.FCS_n) begin
                       m_phase = 0; m_dtack_n = 1; m_oe = 0; m_romcycle = 0;
                   end else m_oe = bus.READ & bus.DOE;
                default: if (bus.FCS_n) begin
                       m_phase = 0; m_berr_n = 1;
                   end
            endcase
        end
    end

    // Every-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            logic [31:0] exp_do;
            for (int i = 0; i < 4; i++)
                exp_do[i*8 +: 8] = bus.DS_n[i] ? 8'h00 : m_rd;
            chk("romcycle",   32'(bus.romcycle),   32'(m_romcycle));
            chk("DTACK_n",    32'(bus.DTACK_n),    32'(m_dtack_n));
            chk("BERR_n",     32'(bus.BERR_n),     32'(m_berr_n));
            chk("data_oe",    32'(bus.data_oe),    32'(m_oe));
            chk("spi_datain", 32'(bus.spi_datain), 32'(m_wr));
            chk("data_out",   bus.data_out,        exp_do);
            chk("term_excl",  32'(!bus.DTACK_n && !bus.BERR_n), 32'(0));
        end
    end

    task automatic idle_bus();
        bus.FCS_n = 1; bus.ADDRH = 8'hE8; bus.configured = 1; bus.READ = 1;
        bus.DOE = 1; bus.DS_n = 4'b0000; bus.D_in = 32'h0; bus.spi_dtack = 0;
        bus.spi_read = 0; bus.spi_dataout = 8'h00;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        IORST_n = 1'b0;
        bus.rom_base = 8'hE8;
        idle_bus();
        tick(); tick();
        // reset state
        chk("rst_romcycle", 32'(bus.romcycle), 32'h0);
        chk("rst_DTACK_n",  32'(bus.DTACK_n),  32'h1);
        chk("rst_BERR_n",   32'(bus.BERR_n),   32'h1);
        chk("rst_data_oe",  32'(bus.data_oe),  32'h0);
        chk("rst_datain",   32'(bus.spi_datain), 32'h0);
        chk("rst_data_out", bus.data_out,      32'h0);
        IORST_n = 1'b1;
        chk_en = 1'b1;
        tick();

        // read cycle
        bus.FCS_n = 0;
        tick();
        chk("rd_romcycle", 32'(bus.romcycle), 32'h1);
        repeat (9) tick();
        bus.spi_dtack = 1; bus.spi_read = 1; bus.spi_dataout = 8'hA5;
        tick();
        bus.spi_dtack = 0; bus.spi_read = 0;
        chk("rd_DTACK_n",  32'(bus.DTACK_n), 32'h0);
        tick();
        chk("rd_data_oe",  32'(bus.data_oe), 32'h1);
        chk("rd_data_out", bus.data_out, 32'hA5A5A5A5);
        bus.FCS_n = 1;
        tick();
        chk("rd_rel_dtack", 32'(bus.DTACK_n), 32'h1);
        chk("rd_rel_oe",    32'(bus.data_oe), 32'h0);
        chk("rd_rel_romcy", 32'(bus.romcycle), 32'h0);

        // write cycle
        bus.READ = 0; bus.DS_n = 4'b1101; bus.D_in = 32'h1122_3344; bus.FCS_n = 0;
        tick();
        chk("wr_datain", 32'(bus.spi_datain), 32'h33);
        repeat (2) tick();
        bus.spi_dtack = 1;
        tick();
        bus.spi_dtack = 0;
        chk("wr_DTACK_n", 32'(bus.DTACK_n), 32'h0);
        tick();
        chk("wr_data_oe", 32'(bus.data_oe), 32'h0);
        bus.FCS_n = 1;
        tick();

        // timeout
        idle_bus();
        bus.FCS_n = 0;
        tick();
        n = 0;
        while (bus.BERR_n && n < 40) begin tick(); n++; end
        chk("tmo_clocks",   32'(n), 32'(int'(TMO) + 1));
        chk("tmo_romcycle", 32'(bus.romcycle), 32'h0);
        tick();
        chk("tmo_berr_hold", 32'(bus.BERR_n), 32'h0);
        bus.FCS_n = 1;
        tick();
        chk("tmo_berr_rel", 32'(bus.BERR_n), 32'h1);

        // abort after 3 clocks
        bus.FCS_n = 0;
        tick();
        repeat (3) tick();
        bus.FCS_n = 1;
        tick();
        chk("abort_romcycle", 32'(bus.romcycle), 32'h0);
        chk("abort_dtack",    32'(bus.DTACK_n),  32'h1);
        chk("abort_berr",     32'(bus.BERR_n),   32'h1);

        // mismatches
        for (int k = 0; k < 3; k++) begin
            idle_bus();
            tick();
            if (k == 0) bus.ADDRH = 8'hE9;
            if (k == 1) bus.configured = 0;
            if (k == 2) bus.DS_n = 4'hF;
            bus.FCS_n = 0;
            tick(); tick();
            chk("nomatch_romcycle", 32'(bus.romcycle), 32'h0);
        end
        idle_bus();
        tick();

        // reset while acknowledging a read
        bus.FCS_n = 0;
        tick();
        bus.spi_dtack = 1; bus.spi_read = 1; bus.spi_dataout = 8'h5A;
        tick();
        bus.spi_dtack = 0;
        tick();
        chk("ack_oe_before_rst", 32'(bus.data_oe), 32'h1);
        #2 IORST_n = 1'b0;
        #1;
        chk("rst_async_dtack", 32'(bus.DTACK_n), 32'h1);
        chk("rst_async_oe",    32'(bus.data_oe), 32'h0);
        tick();
        IORST_n = 1'b1;
        tick();
        chk("rst_fresh_cycle", 32'(bus.romcycle), 32'h1);
        bus.FCS_n = 1;
        tick(); tick();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (bus.FCS_n) bus.FCS_n = ($urandom_range(2) != 0);
            else           bus.FCS_n = ($urandom_range(11) == 0);
            bus.ADDRH       = ($urandom_range(7) == 0) ? 8'hE9 : 8'hE8;
            bus.configured  = ($urandom_range(15) != 0);
            bus.DS_n        = ($urandom_range(9) == 0) ? 4'hF : 4'($urandom);
            bus.READ        = 1'($urandom);
            bus.DOE         = 1'($urandom);
            bus.D_in        = $urandom;
            bus.spi_dtack   = ($urandom_range(9) == 0);
            bus.spi_read    = 1'($urandom);
            bus.spi_dataout = 8'($urandom);
            if ($urandom_range(299) == 0) begin
                #2 IORST_n = 1'b0;
                tick();
                IORST_n = 1'b1;
            end else begin
                tick();
            end
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rom_cycle_ctrl.md
ROM_CYCLE_CTRL -- requirements
Module: rom_cycle_ctrl

Interface
REQ-001 Parameters: TIMEOUT, default 8'd255, clocks in ACTIVE before bus-error termination; LANE_REPLICATE, default 1, when 1 the read byte is driven on all four byte lanes, when 0 only on DS-selected lanes.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 IORST_n  in  1  reset, asynchronous, active-low.
REQ-004 FCS_n  in  1  Zorro III full cycle strobe, active-low.
REQ-005 ADDRH  in  8  bus address bits 31:24.
REQ-006 rom_base  in  8  configured ROM base (A31:24).
REQ-007 configured  in  1  autoconfig complete; no match while low.
REQ-008 READ  in  1  bus read (1) / write (0).
REQ-009 DOE  in  1  bus data output enable.
REQ-010 DS_n  in  4  data strobes; DS_n[3] = D31:24 ... DS_n[0] = D7:0.
REQ-011 D_in  in  32  bus data input.
REQ-012 spi_dtack  in  1  completion from SPI ROM engine.
REQ-013 spi_read  in  1  SPI engine flags valid read byte.
REQ-014 spi_dataout  in  8  read byte from SPI engine.
REQ-015 romcycle  out  1  qualifies SPI ROM engine cycle.
REQ-016 spi_datain  out  8  write byte to SPI engine.
REQ-017 DTACK_n  out  1  bus data acknowledge, active-low.
REQ-018 BERR_n  out  1  bus error, active-low.
REQ-019 data_oe  out  1  bus data driver enable.
REQ-020 data_out  out  32  bus read data.

Function
REQ-021 match = !FCS_n & configured & (ADDRH == rom_base) & ~&DS_n, evaluated combinationally and sampled on the clock edge.
REQ-022 States: IDLE, ACTIVE, ACK, BERR; binary-encoded, 2 bits.
REQ-023 IDLE->ACTIVE on the edge where match=1; same edge: romcycle<=1, tmo<=0, spi_datain<=D_in byte of highest asserted lane, priority DS_n[3]>[2]>[1]>[0].
REQ-024 ACTIVE: romcycle held 1; tmo increments by 1 per clock, 8-bit, saturates and does not wrap.
REQ-025 ACTIVE->ACK on the edge where spi_dtack=1 and FCS_n=0; same edge: DTACK_n<=0; if READ & spi_read, data_rd<=spi_dataout, else data_rd<=8'h00.
REQ-026 ACTIVE->BERR on the edge where tmo==TIMEOUT and spi_dtack=0; same edge: romcycle<=0, BERR_n<=0.
REQ-027 Simultaneous spi_dtack=1 and tmo==TIMEOUT: ACK wins.
REQ-028 ACK: DTACK_n held 0; romcycle held 1; data_oe = READ & DOE, evaluated each clock and registered.
REQ-029 ACK->IDLE on the first edge with FCS_n=1; same edge: DTACK_n<=1, data_oe<=0, romcycle<=0.
REQ-030 BERR->IDLE on the first edge with FCS_n=1; same edge: BERR_n<=1.
REQ-031 Abort: FCS_n=1 while in ACTIVE -> IDLE next edge with romcycle<=0; no DTACK_n or BERR_n pulse.
REQ-032 data_out: LANE_REPLICATE=1 -> {4{data_rd}}; LANE_REPLICATE=0 -> data_rd on lanes with DS_n[i]=0, 8'h00 elsewhere.
REQ-033 No new cycle is accepted in ACK or BERR; re-entry to ACTIVE requires a visit to IDLE, with minimum one clock in IDLE between cycles.
REQ-034 DTACK_n and BERR_n are never low simultaneously.

Reset
REQ-035 IORST_n=0 asynchronously forces: state=IDLE, romcycle=0, DTACK_n=1, BERR_n=1, data_oe=0, data_rd=0, spi_datain=0, tmo=0.
REQ-036 Reset mid-cycle in any state abandons the cycle with no acknowledge; after release, the first match starts a fresh cycle.

Verification
REQ-037 Read: rom_base=8'hE8, configured=1, ADDRH=8'hE8, FCS_n=0, READ=1, DOE=1, DS_n=4'b0000; spi_dtack + spi_read with spi_dataout=8'hA5 after 10 clks -> romcycle 1 clk after match, DTACK_n=0, data_oe=1, data_out=32'hA5A5A5A5; FCS_n=1 -> all released in 1 clk.
REQ-038 Write: READ=0, DS_n=4'b1101, D_in=32'h1122_3344 -> spi_datain=8'h33; data_oe stays 0; DTACK_n=0 after spi_dtack.
REQ-039 Timeout: no spi_dtack -> BERR_n=0 exactly TIMEOUT+1 clocks after entering ACTIVE, romcycle=0; FCS_n=1 -> BERR_n=1.
REQ-040 Abort: FCS_n=1 after 3 clks in ACTIVE -> IDLE, romcycle=0, DTACK_n and BERR_n never asserted.
REQ-041 Mismatch: ADDRH=8'hE9 or configured=0 or DS_n=4'hF -> stays IDLE, romcycle=0.
REQ-042 Reset: IORST_n=0 during ACK -> DTACK_n=1, data_oe=0 immediately, without a clock edge.
